// File: rtl/traffic_lights_pkg.sv
// ---------------------------------------------------------------------------
// traffic_lights_pkg
// Shared definitions for the traffic_lights block, its host-side command
// sequencer and their benches.
//   - CMD_* : command codes carried on the light's cmd_type port
//   - seq_op_t : high-level request opcodes accepted by the sequencer
//   - light_mode_t : coarse light mode (OFF / BLINK / RUN)
//   - seq_state_t : sequencer FSM state, also exported as a debug output
// ---------------------------------------------------------------------------
package traffic_lights_pkg;

  localparam logic [2:0] CMD_ON        = 3'd0;  // OFF->BLINK or BLINK->RUN
  localparam logic [2:0] CMD_OFF       = 3'd1;
  localparam logic [2:0] CMD_BLINK     = 3'd2;  // any running state -> BLINK
  localparam logic [2:0] CMD_GREEN_MS  = 3'd3;
  localparam logic [2:0] CMD_RED_MS    = 3'd4;
  localparam logic [2:0] CMD_YELLOW_MS = 3'd5;

  typedef enum logic [1:0] {
    OP_START    = 2'd0,
    OP_STOP     = 2'd1,
    OP_MAINT    = 2'd2,
    OP_RECONFIG = 2'd3
  } seq_op_t;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_RUN   = 2'd2
  } light_mode_t;

  typedef enum logic [3:0] {
    SEQ_IDLE  = 4'd0,
    SEQ_CHECK = 4'd1,
    SEQ_ENTER = 4'd2,
    SEQ_WR_G  = 4'd3,
    SEQ_WR_R  = 4'd4,
    SEQ_WR_Y  = 4'd5,
    SEQ_GO    = 4'd6,
    SEQ_STOP  = 4'd7,
    SEQ_GAP   = 4'd8,
    SEQ_ERR   = 4'd9
  } seq_state_t;

  // A phase time is usable when non-zero and small enough that the light's
  // internal ms*2 compare cannot overflow.
  function automatic logic time_ok(input logic [15:0] t, input logic [15:0] max_ms);
    return (t != 16'd0) && (t <= max_ms);
  endfunction

endpackage

// File: rtl/traffic_lights_sequencer_if.sv
// ---------------------------------------------------------------------------
// traffic_lights_sequencer_if
// Bundles the sequencer's request port, its command port toward the light
// and its status outputs.
//
// Handshake: a request transfers on a rising clk edge where req_valid_i and
// req_ready_o are both high; the host keeps req_valid_i and all req_* fields
// stable until that edge. cmd_valid_o is a one-cycle strobe with no
// back-pressure: the light must take every command it is shown.
//
// Modports:
//   slave  - the sequencer (consumes requests, drives commands/status)
//   master - the host / bench (drives requests, observes everything else)
// ---------------------------------------------------------------------------
interface traffic_lights_sequencer_if;
  import traffic_lights_pkg::*;

  logic [1:0]  req_op_i;
  logic [15:0] req_red_ms_i;
  logic [15:0] req_yellow_ms_i;
  logic [15:0] req_green_ms_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  cmd_type_o;
  logic [15:0] cmd_data_o;
  logic        cmd_valid_o;
  light_mode_t mode_o;
  logic        busy_o;
  logic        err_o;

  modport slave (
    input  req_op_i, req_red_ms_i, req_yellow_ms_i, req_green_ms_i, req_valid_i,
    output req_ready_o, cmd_type_o, cmd_data_o, cmd_valid_o, mode_o, busy_o, err_o
  );

  modport master (
    output req_op_i, req_red_ms_i, req_yellow_ms_i, req_green_ms_i, req_valid_i,
    input  req_ready_o, cmd_type_o, cmd_data_o, cmd_valid_o, mode_o, busy_o, err_o
  );

endinterface

// File: rtl/traffic_lights_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_lights_sequencer
// Expands START / STOP / MAINT / RECONFIG requests into the ordered command
// strobes a traffic_lights instance needs, tracking a shadow of the light's
// mode so timing writes are only issued while the light is in yellow-blink.
//
// Parameters:
//   CMD_GAP - idle cycles after every issued command (0 allowed)
//   MAX_MS  - largest legal phase time
// Ports:
//   clk_i       - clock
//   srst_i      - synchronous active-high reset (shared with the light)
//   bus         - request / command / status bundle (slave side)
//   dbg_state_o - current FSM state, for observation only
// Build option:
//   TRAFFIC_LIGHTS_SEQ_CFG_CACHE_EN - remember the last written times and
//   skip timing writes that would not change the light's value.
// ---------------------------------------------------------------------------
module traffic_lights_sequencer
  import traffic_lights_pkg::*;
#(
  parameter int          CMD_GAP = 1,
  parameter logic [15:0] MAX_MS  = 16'h7FFF
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  traffic_lights_sequencer_if.slave   bus,
  output seq_state_t                  dbg_state_o
);

  localparam int GAP_W = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
  // GAP is entered for CMD_GAP cycles, so the counter starts at CMD_GAP-1.
  localparam logic [GAP_W-1:0] GAP_LOAD = (CMD_GAP > 0) ? GAP_W'(CMD_GAP - 1) : '0;

  seq_state_t       r_state, w_next_state;
  seq_state_t       r_ret, w_next_ret;
  logic [GAP_W-1:0] r_gap_cnt;

  seq_op_t          r_op;
  logic [15:0]      r_red, r_yellow, r_green;
  light_mode_t      r_mode;
  logic [2:0]       r_enter_cmd;

  logic             w_accept;
  logic             w_legal;
  logic             w_need_g, w_need_r, w_need_y;
  seq_state_t       w_after_y, w_after_r, w_after_g, w_after_enter, w_after_check;
  seq_state_t       w_succ;

  logic             w_ready, w_cmd_valid, w_err;
  logic [2:0]       w_cmd_type;
  logic [15:0]      w_cmd_data;

  assign w_accept = (r_state == SEQ_IDLE) && bus.req_valid_i;

`ifdef TRAFFIC_LIGHTS_SEQ_CFG_CACHE_EN
  // Last values written to the light. The flag is set together with the
  // yellow write: when the flag was clear every write of that sequence was
  // issued, and yellow is the last of them.
  logic        r_cache_vld;
  logic [15:0] r_cache_g, r_cache_r, r_cache_y;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_cache_vld <= 1'b0;
      r_cache_g   <= '0;
      r_cache_r   <= '0;
      r_cache_y   <= '0;
    end else begin
      if (w_next_state == SEQ_WR_G) r_cache_g <= r_green;
      if (w_next_state == SEQ_WR_R) r_cache_r <= r_red;
      if (w_next_state == SEQ_WR_Y) begin
        r_cache_y   <= r_yellow;
        r_cache_vld <= 1'b1;
      end
    end
  end

  assign w_need_g = !(r_cache_vld && (r_cache_g == r_green));
  assign w_need_r = !(r_cache_vld && (r_cache_r == r_red));
  assign w_need_y = !(r_cache_vld && (r_cache_y == r_yellow));
`else
  assign w_need_g = 1'b1;
  assign w_need_r = 1'b1;
  assign w_need_y = 1'b1;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= SEQ_IDLE;
      r_ret   <= SEQ_IDLE;
    end else begin
      r_state <= w_next_state;
      r_ret   <= w_next_ret;
    end
  end

  // Next-state logic. The w_after_* chain gives the command step that
  // follows each step for the latched request, with skipped steps folded out.
  always_comb begin
    w_legal = time_ok(r_red, MAX_MS) && time_ok(r_yellow, MAX_MS) &&
              time_ok(r_green, MAX_MS);

    w_after_y     = (r_op == OP_START) ? SEQ_GO : SEQ_IDLE;
    w_after_r     = w_need_y ? SEQ_WR_Y : w_after_y;
    w_after_g     = w_need_r ? SEQ_WR_R : w_after_r;
    w_after_enter = (r_op == OP_MAINT) ? SEQ_IDLE :
                    (w_need_g ? SEQ_WR_G : w_after_g);

    case (r_op)
      OP_STOP:  w_after_check = (r_mode != MODE_OFF) ? SEQ_STOP : SEQ_IDLE;
      OP_MAINT: w_after_check = (r_mode != MODE_BLINK) ? SEQ_ENTER : SEQ_IDLE;
      default:  w_after_check = !w_legal ? SEQ_ERR :
                                ((r_mode != MODE_BLINK) ? SEQ_ENTER : w_after_enter);
    endcase

    case (r_state)
      SEQ_ENTER: w_succ = w_after_enter;
      SEQ_WR_G:  w_succ = w_after_g;
      SEQ_WR_R:  w_succ = w_after_r;
      SEQ_WR_Y:  w_succ = w_after_y;
      default:   w_succ = SEQ_IDLE;
    endcase

    w_next_state = r_state;
    w_next_ret   = r_ret;
    case (r_state)
      SEQ_IDLE:  if (bus.req_valid_i) w_next_state = SEQ_CHECK;
      SEQ_CHECK: w_next_state = w_after_check;
      SEQ_ENTER, SEQ_WR_G, SEQ_WR_R, SEQ_WR_Y, SEQ_GO, SEQ_STOP: begin
        if (CMD_GAP > 0) begin
          w_next_state = SEQ_GAP;
          w_next_ret   = w_succ;
        end else begin
          w_next_state = w_succ;
        end
      end
      SEQ_GAP:   if (r_gap_cnt == '0) w_next_state = r_ret;
      SEQ_ERR:   w_next_state = SEQ_IDLE;
      default:   w_next_state = SEQ_IDLE;
    endcase
  end

  // Operand latch, gap counter and shadow mode
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_op        <= OP_START;
      r_red       <= '0;
      r_yellow    <= '0;
      r_green     <= '0;
      r_mode      <= MODE_OFF;
      r_enter_cmd <= CMD_ON;
      r_gap_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= seq_op_t'(bus.req_op_i);
        r_red    <= bus.req_red_ms_i;
        r_yellow <= bus.req_yellow_ms_i;
        r_green  <= bus.req_green_ms_i;
      end

      // Captured before the mode moves on the edge that issues ENTER.
      if (r_state == SEQ_CHECK)
        r_enter_cmd <= (r_mode == MODE_OFF) ? CMD_ON : CMD_BLINK;

      if ((w_next_state == SEQ_GAP) && (r_state != SEQ_GAP))
        r_gap_cnt <= GAP_LOAD;
      else if ((r_state == SEQ_GAP) && (r_gap_cnt != '0))
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);

      // Mode follows the command on the edge that raises its strobe.
      case (w_next_state)
        SEQ_ENTER: r_mode <= MODE_BLINK;
        SEQ_GO:    r_mode <= MODE_RUN;
        SEQ_STOP:  r_mode <= MODE_OFF;
        default:   r_mode <= r_mode;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    w_ready     = 1'b0;
    w_cmd_valid = 1'b0;
    w_cmd_type  = CMD_ON;
    w_cmd_data  = '0;
    w_err       = 1'b0;
    case (r_state)
      SEQ_IDLE:  w_ready = 1'b1;
      SEQ_ENTER: begin
        w_cmd_valid = 1'b1;
        w_cmd_type  = r_enter_cmd;
      end
      SEQ_WR_G: begin
        w_cmd_valid = 1'b1;
        w_cmd_type  = CMD_GREEN_MS;
        w_cmd_data  = r_green;
      end
      SEQ_WR_R: begin
        w_cmd_valid = 1'b1;
        w_cmd_type  = CMD_RED_MS;
        w_cmd_data  = r_red;
      end
      SEQ_WR_Y: begin
        w_cmd_valid = 1'b1;
        w_cmd_type  = CMD_YELLOW_MS;
        w_cmd_data  = r_yellow;
      end
      SEQ_GO: begin
        w_cmd_valid = 1'b1;
        w_cmd_type  = CMD_ON;
      end
      SEQ_STOP: begin
        w_cmd_valid = 1'b1;
        w_cmd_type  = CMD_OFF;
      end
      SEQ_ERR:   w_err = 1'b1;
      default:   w_ready = 1'b0;
    endcase
  end

  assign bus.req_ready_o = w_ready;
  assign bus.busy_o      = !w_ready;
  assign bus.cmd_valid_o = w_cmd_valid;
  assign bus.cmd_type_o  = w_cmd_type;
  assign bus.cmd_data_o  = w_cmd_data;
  assign bus.err_o       = w_err;
  assign bus.mode_o      = r_mode;
  assign dbg_state_o     = r_state;

endmodule

// File: doc/traffic_lights_sequencer.md
# traffic_lights_sequencer

Host-side command sequencer for one `traffic_lights` instance. Accepts high-level requests (start, stop, maintenance blink, reconfigure) over a valid/ready port. Expands each request into the ordered single-cycle command strobes the light needs on its `cmd_type`/`cmd_valid`/`cmd_data` port. Keeps a shadow of the light's mode, so timing writes land only while the light is in yellow-blink, where it accepts them.

## Interface
Parameters:
- `CMD_GAP`, 1: idle cycles inserted after every issued command (0 allowed).
- `MAX_MS`, 16'h7FFF: largest legal phase time; larger values overflow the light's `ms*2` compare.

Ports:
- `clk_i`  in  1  clock.
- `srst_i`  in  1  reset. One clock; reset is synchronous and active-high. Must be the same reset as the driven light.
- `req_op_i`  in  2  0 START, 1 STOP, 2 MAINT, 3 RECONFIG.
- `req_red_ms_i`  in  16  red time for START/RECONFIG.
- `req_yellow_ms_i`  in  16  yellow time.
- `req_green_ms_i`  in  16  green time.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `cmd_type_o`  out  3  to light `cmd_type_i`.
- `cmd_data_o`  out  16  to light `cmd_data_i`.
- `cmd_valid_o`  out  1  to light `cmd_valid_i`; one-cycle pulse per command.
- `mode_o`  out  2  shadow light mode: 0 OFF, 1 BLINK, 2 RUN.
- `busy_o`  out  1  equal to `!req_ready_o`.
- `err_o`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Light command codes:
  - 0 ON: OFF→BLINK, or BLINK→RUN.
  - 1 OFF.
  - 2 BLINK: any running state→BLINK.
  - 3 green time.
  - 4 red time.
  - 5 yellow time.
- FSM states: IDLE, CHECK, ENTER, WR_G, WR_R, WR_Y, GO, STOP, GAP, ERR. GAP holds a return-state register and a down-counter.
- Operands are latched on acceptance.
- START:
  - Illegal operands: any time equal to 0 or greater than `MAX_MS` → ERR, no commands issued.
  - Otherwise the command sequence depends on the shadow mode. The ENTER command is 0 from OFF, none from BLINK, 2 from RUN.
  - It then issues WR_G (3, green), WR_R (4, red), WR_Y (5, yellow), then GO (0).
  - End mode: RUN.
- RECONFIG: same legality check and ENTER/WR steps as START, without GO. End mode: BLINK.
- STOP: issues 1 unless the mode is already OFF, in which case nothing is issued. End mode: OFF.
- MAINT: issues 0 from OFF, nothing from BLINK, 2 from RUN. End mode: BLINK.
- `cmd_data_o` carries the time value during WR_* and is 0 otherwise.
- `mode_o` updates on the same edge that raises `cmd_valid_o` for a mode-changing command.
- A request that issues no commands returns to IDLE after CHECK with no `err_o`.

## Timing
- Reset values: `req_ready_o`=1, `cmd_valid_o`=0, `cmd_type_o`=0, `cmd_data_o`=0, `mode_o`=OFF, `busy_o`=0, `err_o`=0.
- `req_ready_o` is high only in IDLE. Acceptance edge = cycle 0. CHECK = cycle 1.
- First command at cycle 2. Commands are spaced `CMD_GAP`+1 cycles apart.
- After the last command, the FSM spends `CMD_GAP` cycles in GAP, then enters IDLE.
- START from OFF with `CMD_GAP`=1:
  - Commands at cycles 2, 4, 6, 8, 10.
  - `req_ready_o` high again at cycle 12.
- Rejected request: `err_o`=1 at cycle 2, ready at cycle 3.
- Zero-command request: ready at cycle 2.
- `srst_i` mid-sequence aborts. On the next cycle all outputs hold reset values, including mode OFF, which matches the light's own reset.
- `req_valid_i` while busy is ignored. The host holds the request until ready.

## Configuration
- `TRAFFIC_LIGHTS_SEQ_CFG_CACHE_EN` defined:
  - Keep last-written green/red/yellow values plus a valid flag. Reset clears the flag.
  - Skip any WR_* whose value equals the cached value while the flag is valid. Skipped steps produce no command and no gap.
  - Cache updates on each issued write.
- Undefined: all three writes are always issued; no cache registers.

## Structure
- Shared `traffic_lights_pkg` holds:
  - Command code localparams (CMD_ON=0 … CMD_YELLOW_MS=5).
  - `seq_op_t` enum (START/STOP/MAINT/RECONFIG).
  - `light_mode_t` enum (OFF/BLINK/RUN).
  - These are shared with `traffic_lights` and benches.
- No sub-module. The gap counter is inline, `$clog2(CMD_GAP+1)` bits, min 1.

## Test plan
- Reset, START red=10 yellow=3 green=8, `CMD_GAP`=1 → cmds (0,0),(3,8),(4,10),(5,3),(0,0) at cycles 2/4/6/8/10; mode OFF→BLINK→RUN; ready at 12.
- In RUN, STOP → single cmd 1 at cycle 2, mode OFF. Repeat STOP → no cmd, ready at cycle 2, no err.
- START with green=0, then START with red=16'h8000 → `err_o` pulse each, zero commands, mode unchanged.
- In RUN, RECONFIG red=5 yellow=2 green=4 → cmds 2,(3,4),(4,5),(5,2), mode BLINK; then MAINT → no cmd.
- Reset asserted at cycle 5 of a START → next cycle `cmd_valid_o`=0, mode OFF, ready=1; fresh START begins again with cmd 0.
- With `TRAFFIC_LIGHTS_SEQ_CFG_CACHE_EN`: START, STOP, START with identical times → second START issues only 0,0; changing yellow only → 0,(5,new),0.
